// File: rtl/eater_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, control-word bit positions, step type.
// Combinational constants only; no latency, no backpressure.
package eater_pkg;

    typedef logic [2:0] step_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CTRL_HLT = 15;
    localparam int CTRL_MI  = 14;
    localparam int CTRL_RI  = 13;
    localparam int CTRL_RO  = 12;
    localparam int CTRL_IO  = 11;
    localparam int CTRL_II  = 10;
    localparam int CTRL_AI  = 9;
    localparam int CTRL_AO  = 8;
    localparam int CTRL_EO  = 7;
    localparam int CTRL_SU  = 6;
    localparam int CTRL_BI  = 5;
    localparam int CTRL_OI  = 4;
    localparam int CTRL_CE  = 3;
    localparam int CTRL_CO  = 2;
    localparam int CTRL_J   = 1;
    localparam int CTRL_FI  = 0;

    localparam logic [15:0] M_HLT = 16'h1 << CTRL_HLT;
    localparam logic [15:0] M_MI  = 16'h1 << CTRL_MI;
    localparam logic [15:0] M_RI  = 16'h1 << CTRL_RI;
    localparam logic [15:0] M_RO  = 16'h1 << CTRL_RO;
    localparam logic [15:0] M_IO  = 16'h1 << CTRL_IO;
    localparam logic [15:0] M_II  = 16'h1 << CTRL_II;
    localparam logic [15:0] M_AI  = 16'h1 << CTRL_AI;
    localparam logic [15:0] M_AO  = 16'h1 << CTRL_AO;
    localparam logic [15:0] M_EO  = 16'h1 << CTRL_EO;
    localparam logic [15:0] M_SU  = 16'h1 << CTRL_SU;
    localparam logic [15:0] M_BI  = 16'h1 << CTRL_BI;
    localparam logic [15:0] M_OI  = 16'h1 << CTRL_OI;
    localparam logic [15:0] M_CE  = 16'h1 << CTRL_CE;
    localparam logic [15:0] M_CO  = 16'h1 << CTRL_CO;
    localparam logic [15:0] M_J   = 16'h1 << CTRL_J;
    localparam logic [15:0] M_FI  = 16'h1 << CTRL_FI;

    // Last active T-step per opcode, entry 15 (HLT) first; undefined opcodes behave as NOP.
    localparam logic [15:0][2:0] LAST_STEP_TBL = {
        3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2,
        3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd1
    };

endpackage

// File: rtl/control_sequencer_if.sv
// Opcode/flag inputs and control-word/status outputs of the control sequencer.
// Wires only; no latency, no backpressure.
interface control_sequencer_if;
    import eater_pkg::*;

    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl;
    step_t       step;
    logic        halted;

    modport master (output opcode, flag_c, flag_z, input ctrl, step, halted);
    modport slave  (input opcode, flag_c, flag_z, output ctrl, step, halted);
endinterface

// File: rtl/eater_microcode_rom.sv
// Microcode lookup: (opcode, step, flags) -> control word plus last-step marker.
// Purely combinational; no backpressure.
module eater_microcode_rom
    import eater_pkg::*;
(
    input  logic [3:0]  opcode,
    input  step_t       step,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic        last
);

    always_comb begin
        ctrl = '0;
        // T1 needs the opcode too: NOP-class instructions end there.
        last = (step == LAST_STEP_TBL[opcode]);
        case (step)
            3'd0: ctrl = M_CO | M_MI;
            3'd1: ctrl = M_RO | M_II | M_CE;
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = M_IO | M_MI;
                    OP_LDI: ctrl = M_IO | M_AI;
                    OP_JMP: ctrl = M_IO | M_J;
                    OP_JC:  ctrl = flag_c ? (M_IO | M_J) : 16'h0000;
                    OP_JZ:  ctrl = flag_z ? (M_IO | M_J) : 16'h0000;
                    OP_OUT: ctrl = M_AO | M_OI;
                    OP_HLT: ctrl = M_HLT;
                    default: ctrl = '0;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA:         ctrl = M_RO | M_AI;
                    OP_ADD, OP_SUB: ctrl = M_RO | M_BI;
                    OP_STA:         ctrl = M_AO | M_RI;
                    default:        ctrl = '0;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD:  ctrl = M_EO | M_AI | M_FI;
                    OP_SUB:  ctrl = M_EO | M_AI | M_SU | M_FI;
                    default: ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// T-step sequencer and halt latch driving the datapath control word from the microcode ROM.
// ctrl is combinational from the current step (zero added latency); no backpressure.
module control_sequencer
    import eater_pkg::*;
#(
    parameter int MAX_STEPS = 5,
    parameter bit EARLY_END = 1'b1
)(
    input  logic               clk,
    input  logic               rst,
    control_sequencer_if.slave bus
);

    localparam step_t STEP_WRAP = step_t'(MAX_STEPS - 1);

    step_t       step_q;
    step_t       step_d;
    logic        halted_q;
    logic        halted_d;
    logic [15:0] rom_ctrl;
    logic        rom_last;

    eater_microcode_rom u_rom (
        .opcode (bus.opcode),
        .step   (step_q),
        .flag_c (bus.flag_c),
        .flag_z (bus.flag_z),
        .ctrl   (rom_ctrl),
        .last   (rom_last)
    );

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            // HLT freezes the step counter where it is; only reset releases it.
            if (rom_ctrl[CTRL_HLT]) begin
                halted_d = 1'b1;
            end else if ((EARLY_END && rom_last) || (step_q == STEP_WRAP)) begin
                step_d = '0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        bus.ctrl = rom_ctrl;
        if (rst) begin
            bus.ctrl = '0;
        end else if (halted_q) begin
            bus.ctrl = M_HLT;
        end
    end

    assign bus.step   = step_q;
    assign bus.halted = halted_q;

endmodule
